// File: rtl/sent_rx_pkg.sv
// Shared SENT RX definitions: FIFO word width, word tags and arbiter FSM states.
// Also used by sent_rx_control and the RX FIFO reader.
package sent_rx_pkg;

  localparam int unsigned SENT_FIFO_W = 12;
  localparam int unsigned SLOW_ID_W   = 8;
  localparam int unsigned SLOW_DATA_W = 16;
  localparam int unsigned SLOW_MSG_W  = SLOW_ID_W + SLOW_DATA_W;

  localparam logic [1:0] TAG_FAST    = 2'b00;
  localparam logic [1:0] TAG_SLOW_HI = 2'b01;
  localparam logic [1:0] TAG_SLOW_LO = 2'b10;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_SLOW_LO = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [SLOW_ID_W-1:0]   id;
    logic [SLOW_DATA_W-1:0] data;
  } slow_msg_t;

endpackage

// File: rtl/sent_rx_small_buf.sv
// Small circular buffer with synchronous push/pop; a push on a full buffer is
// accepted only when a pop happens on the same edge.
module sent_rx_small_buf #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_rx,
  input  logic             reset_rx,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (occ == '0);
  assign full      = (occ == OCC_W'(DEPTH));
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (do_pop && !do_push) occ <= occ - 1'b1;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk_rx) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sent_rx_fifo_arbiter.sv
// Round-robin sharing of the RX FIFO write port between the fast-word stream
// and slow-channel messages (each slow message becomes a hi/lo tagged pair).
module sent_rx_fifo_arbiter
  import sent_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = SENT_FIFO_W,
  parameter int unsigned FAST_DEPTH = 2,
  parameter int unsigned SLOW_DEPTH = 1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                   clk_rx,
  input  logic                   reset_rx,
  input  logic                   arb_enable,
  input  logic                   fast_valid,
  input  logic [DATA_W-1:0]      fast_data,
  output logic                   fast_ready,
  input  logic                   slow_valid,
  input  logic [SLOW_ID_W-1:0]   slow_id,
  input  logic [SLOW_DATA_W-1:0] slow_data,
  output logic                   slow_ready,
  input  logic                   fifo_afull,
  output logic                   write_enable_rx,
  output logic [DATA_W-1:0]      data_to_fifo_rx,
  output logic [1:0]             tag_to_fifo_rx,
  output logic [CNT_W-1:0]       fast_drop_cnt,
  output logic [CNT_W-1:0]       slow_drop_cnt
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic              rr_slow;
  logic              fast_full, fast_empty;
  logic              slow_full, slow_empty;
  logic [DATA_W-1:0] fast_head;
  slow_msg_t         slow_head;
  slow_msg_t         slow_in;
  logic              can_grant_c;
  logic              pick_slow_c;
  logic              pop_fast_c, pop_slow_c;
  logic              wr_c;
  logic [DATA_W-1:0] wr_data_c;
  logic [1:0]        wr_tag_c;
  logic              fast_drop_c, slow_drop_c;

  assign slow_in = '{id: slow_id, data: slow_data};

  sent_rx_small_buf #(.WIDTH(DATA_W), .DEPTH(FAST_DEPTH)) u_fast_buf (
    .clk_rx    (clk_rx),
    .reset_rx  (reset_rx),
    .push      (fast_valid),
    .push_data (fast_data),
    .pop       (pop_fast_c),
    .full      (fast_full),
    .empty     (fast_empty),
    .head_data (fast_head)
  );

  sent_rx_small_buf #(.WIDTH(SLOW_MSG_W), .DEPTH(SLOW_DEPTH)) u_slow_buf (
    .clk_rx    (clk_rx),
    .reset_rx  (reset_rx),
    .push      (slow_valid),
    .push_data (slow_in),
    .pop       (pop_slow_c),
    .full      (slow_full),
    .empty     (slow_empty),
    .head_data (slow_head)
  );

  assign fast_ready  = ~fast_full;
  assign slow_ready  = ~slow_full;
  assign fast_drop_c = fast_valid & fast_full & ~pop_fast_c;
  assign slow_drop_c = slow_valid & slow_full & ~pop_slow_c;

  // On a tie the RR pointer decides; otherwise the only non-empty source wins.
  assign can_grant_c = arb_enable & ~fifo_afull & (~fast_empty | ~slow_empty);
  assign pick_slow_c = ~slow_empty & (fast_empty | rr_slow);

  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:    if (can_grant_c && pick_slow_c) state_nxt = ARB_SLOW_LO;
      ARB_SLOW_LO: if (!fifo_afull) state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    pop_fast_c = 1'b0;
    pop_slow_c = 1'b0;
    wr_c       = 1'b0;
    wr_data_c  = '0;
    wr_tag_c   = TAG_FAST;
    case (state)
      ARB_IDLE: begin
        if (can_grant_c) begin
          wr_c = 1'b1;
          if (pick_slow_c) begin
            wr_data_c = DATA_W'({slow_head.id, slow_head.data[15:12]});
            wr_tag_c  = TAG_SLOW_HI;
          end else begin
            wr_data_c  = fast_head;
            pop_fast_c = 1'b1;
          end
        end
      end
      ARB_SLOW_LO: begin
        if (!fifo_afull) begin
          wr_c       = 1'b1;
          wr_data_c  = DATA_W'(slow_head.data[11:0]);
          wr_tag_c   = TAG_SLOW_LO;
          pop_slow_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered write port; data and tag hold between strobes.
  always_ff @(posedge clk_rx or posedge reset_rx) begin
    if (reset_rx) begin
      write_enable_rx <= 1'b0;
      data_to_fifo_rx <= '0;
      tag_to_fifo_rx  <= TAG_FAST;
      rr_slow         <= 1'b0;
      fast_drop_cnt   <= '0;
      slow_drop_cnt   <= '0;
    end else begin
      write_enable_rx <= wr_c;
      if (wr_c) begin
        data_to_fifo_rx <= wr_data_c;
        tag_to_fifo_rx  <= wr_tag_c;
      end
      if (state == ARB_IDLE && can_grant_c) rr_slow <= ~pick_slow_c;
      if (fast_drop_c && fast_drop_cnt != '1) fast_drop_cnt <= fast_drop_cnt + 1'b1;
      if (slow_drop_c && slow_drop_cnt != '1) slow_drop_cnt <= slow_drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sent_rx_fifo_arbiter.sv
// Bench for sent_rx_fifo_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_sent_rx_fifo_arbiter;

  localparam int unsigned FD = 2;
  localparam int unsigned SD = 1;

  logic        clk_rx = 1'b0;
  logic        reset_rx;
  logic        arb_enable;
  logic        fast_valid;
  logic [11:0] fast_data;
  logic        fast_ready;
  logic        slow_valid;
  logic [7:0]  slow_id;
  logic [15:0] slow_data;
  logic        slow_ready;
  logic        fifo_afull;
  logic        write_enable_rx;
  logic [11:0] data_to_fifo_rx;
  logic [1:0]  tag_to_fifo_rx;
  logic [7:0]  fast_drop_cnt;
  logic [7:0]  slow_drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain queues of pending work plus expected output values.
  logic [11:0] fq[$];
  logic [23:0] sq[$];
  bit          m_lo_pending;
  bit          m_next_slow;
  bit          exp_we;
  logic [11:0] exp_data;
  logic [1:0]  exp_tag;
  logic [7:0]  exp_fcnt;
  logic [7:0]  exp_scnt;

  sent_rx_fifo_arbiter dut (
    .clk_rx          (clk_rx),
    .reset_rx        (reset_rx),
    .arb_enable      (arb_enable),
    .fast_valid      (fast_valid),
    .fast_data       (fast_data),
    .fast_ready      (fast_ready),
    .slow_valid      (slow_valid),
    .slow_id         (slow_id),
    .slow_data       (slow_data),
    .slow_ready      (slow_ready),
    .fifo_afull      (fifo_afull),
    .write_enable_rx (write_enable_rx),
    .data_to_fifo_rx (data_to_fifo_rx),
    .tag_to_fifo_rx  (tag_to_fifo_rx),
    .fast_drop_cnt   (fast_drop_cnt),
    .slow_drop_cnt   (slow_drop_cnt)
  );

  always #5 clk_rx = ~clk_rx;

  task automatic model_reset();
    fq.delete();
    sq.delete();
    m_lo_pending = 0;
    m_next_slow  = 0;
    exp_we   = 0;
    exp_data = '0;
    exp_tag  = 2'b00;
    exp_fcnt = '0;
    exp_scnt = '0;
  endtask

  // Advance one clock: predict the edge from current inputs, then clear pulses.
  task automatic step();
    bit          wr = 0;
    bit          pf = 0;
    bit          ps = 0;
    bit          go_lo = 0;
    logic [11:0] wd = '0;
    logic [1:0]  wt = '0;
    bit          fv = fast_valid;
    bit          sv = slow_valid;
    logic [11:0] fdat = fast_data;
    logic [23:0] smsg = {slow_id, slow_data};
    int          fsz = fq.size();
    int          ssz = sq.size();
    if (m_lo_pending) begin
      if (!fifo_afull) begin
        wr = 1; wd = sq[0][11:0]; wt = 2'b10; ps = 1;
      end
    end else if (arb_enable && !fifo_afull && (fsz > 0 || ssz > 0)) begin
      wr = 1;
      if (ssz > 0 && (fsz == 0 || m_next_slow)) begin
        wd = {sq[0][23:16], sq[0][15:12]}; wt = 2'b01; go_lo = 1; m_next_slow = 0;
      end else begin
        wd = fq[0]; wt = 2'b00; pf = 1; m_next_slow = 1;
      end
    end
    @(posedge clk_rx);
    #1;
    if (pf) void'(fq.pop_front());
    if (ps) begin void'(sq.pop_front()); m_lo_pending = 0; end
    if (go_lo) m_lo_pending = 1;
    if (fv) begin
      if (fsz < FD || pf) fq.push_back(fdat);
      else if (exp_fcnt != 8'hFF) exp_fcnt++;
    end
    if (sv) begin
      if (ssz < SD || ps) sq.push_back(smsg);
      else if (exp_scnt != 8'hFF) exp_scnt++;
    end
    exp_we = wr;
    if (wr) begin exp_data = wd; exp_tag = wt; end
    fast_valid = 0;
    slow_valid = 0;
  endtask

  task automatic test_reset();
    reset_rx = 1; arb_enable = 0; fast_valid = 0; fast_data = '0;
    slow_valid = 0; slow_id = '0; slow_data = '0; fifo_afull = 0;
    model_reset();
    #23 reset_rx = 0;
    #1;
    checks++;
    if (write_enable_rx !== 1'b0 || data_to_fifo_rx !== 12'h000 || tag_to_fifo_rx !== 2'b00 ||
        fast_drop_cnt !== 8'd0 || slow_drop_cnt !== 8'd0 || fast_ready !== 1'b1 || slow_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: we=%b data=%h tag=%b fcnt=%0d scnt=%0d frdy=%b srdy=%b, required all zero and readies 1",
               write_enable_rx, data_to_fifo_rx, tag_to_fifo_rx, fast_drop_cnt, slow_drop_cnt, fast_ready, slow_ready);
    end
    @(negedge clk_rx);
  endtask

  task automatic test_fast_words();
    arb_enable = 1; fifo_afull = 0;
    fast_valid = 1; fast_data = 12'h123;
    step();
    checks++;
    if (write_enable_rx !== 1'b0) begin failures++; $display("FAIL fast_capture_edge: we=%b required 0", write_enable_rx); end
    step();
    checks++;
    if (write_enable_rx !== 1'b1 || data_to_fifo_rx !== 12'h123 || tag_to_fifo_rx !== 2'b00) begin
      failures++; $display("FAIL fast_first: we=%b data=%h tag=%b required 1/123/00", write_enable_rx, data_to_fifo_rx, tag_to_fifo_rx);
    end
    fast_valid = 1; fast_data = 12'hABC;
    step();
    checks++;
    if (write_enable_rx !== 1'b0 || data_to_fifo_rx !== 12'h123) begin
      failures++; $display("FAIL fast_hold: we=%b data=%h required 0/123", write_enable_rx, data_to_fifo_rx);
    end
    step();
    checks++;
    if (write_enable_rx !== 1'b1 || data_to_fifo_rx !== 12'hABC || tag_to_fifo_rx !== 2'b00) begin
      failures++; $display("FAIL fast_second: we=%b data=%h tag=%b required 1/abc/00", write_enable_rx, data_to_fifo_rx, tag_to_fifo_rx);
    end
  endtask

  task automatic test_slow_pair();
    slow_valid = 1; slow_id = 8'h5A; slow_data = 16'hBEEF;
    step();
    checks++;
    if (slow_ready !== 1'b0) begin failures++; $display("FAIL slow_full_ready: slow_ready=%b required 0", slow_ready); end
    step();
    checks++;
    if (write_enable_rx !== 1'b1 || data_to_fifo_rx !== 12'h5AB || tag_to_fifo_rx !== 2'b01) begin
      failures++; $display("FAIL slow_hi: we=%b data=%h tag=%b required 1/5ab/01", write_enable_rx, data_to_fifo_rx, tag_to_fifo_rx);
    end
    step();
    checks++;
    if (write_enable_rx !== 1'b1 || data_to_fifo_rx !== 12'hEEF || tag_to_fifo_rx !== 2'b10) begin
      failures++; $display("FAIL slow_lo: we=%b data=%h tag=%b required 1/eef/10", write_enable_rx, data_to_fifo_rx, tag_to_fifo_rx);
    end
    step();
    checks++;
    if (write_enable_rx !== 1'b0 || slow_ready !== 1'b1) begin
      failures++; $display("FAIL slow_done: we=%b srdy=%b required 0/1", write_enable_rx, slow_ready);
    end
  endtask

  task automatic test_round_robin();
    for (int round = 0; round < 2; round++) begin
      logic [11:0] fw = 12'($urandom);
      logic [7:0]  sid = 8'($urandom);
      logic [15:0] sdat = 16'($urandom);
      logic [11:0] exp_seq [3];
      logic [1:0]  exp_tags [3];
      exp_seq[0] = fw;                   exp_tags[0] = 2'b00;
      exp_seq[1] = {sid, sdat[15:12]};   exp_tags[1] = 2'b01;
      exp_seq[2] = sdat[11:0];           exp_tags[2] = 2'b10;
      fast_valid = 1; fast_data = fw; slow_valid = 1; slow_id = sid; slow_data = sdat;
      step();
      for (int k = 0; k < 3; k++) begin
        step();
        checks++;
        if (write_enable_rx !== 1'b1 || data_to_fifo_rx !== exp_seq[k] || tag_to_fifo_rx !== exp_tags[k]) begin
          failures++;
          $display("FAIL rr_order round%0d word%0d: we=%b data=%h tag=%b required 1/%h/%b",
                   round, k, write_enable_rx, data_to_fifo_rx, tag_to_fifo_rx, exp_seq[k], exp_tags[k]);
        end
      end
    end
  endtask

  task automatic test_afull_hold();
    logic [11:0] fw = 12'($urandom);
    slow_valid = 1; slow_id = 8'hC3; slow_data = 16'h1234;
    step();
    step();
    checks++;
    if (write_enable_rx !== 1'b1 || tag_to_fifo_rx !== 2'b01 || data_to_fifo_rx !== 12'hC31) begin
      failures++; $display("FAIL hold_hi: we=%b data=%h tag=%b required 1/c31/01", write_enable_rx, data_to_fifo_rx, tag_to_fifo_rx);
    end
    fifo_afull = 1; fast_valid = 1; fast_data = fw;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (write_enable_rx !== 1'b0) begin failures++; $display("FAIL hold_no_strobe cyc%0d: we=%b required 0", c, write_enable_rx); end
    end
    fifo_afull = 0;
    step();
    checks++;
    if (write_enable_rx !== 1'b1 || data_to_fifo_rx !== 12'h234 || tag_to_fifo_rx !== 2'b10) begin
      failures++; $display("FAIL hold_lo: we=%b data=%h tag=%b required 1/234/10", write_enable_rx, data_to_fifo_rx, tag_to_fifo_rx);
    end
    step();
    checks++;
    if (write_enable_rx !== 1'b1 || data_to_fifo_rx !== fw || tag_to_fifo_rx !== 2'b00) begin
      failures++; $display("FAIL hold_fast_after: we=%b data=%h tag=%b required 1/%h/00", write_enable_rx, data_to_fifo_rx, tag_to_fifo_rx, fw);
    end
    step();
  endtask

  task automatic test_drop_saturation();
    logic [11:0] kept [2];
    fifo_afull = 1;
    for (int p = 0; p < 4; p++) begin
      fast_valid = 1; fast_data = 12'($urandom);
      if (p < 2) kept[p] = fast_data;
      step();
      if (p == 1) begin
        checks++;
        if (fast_ready !== 1'b0) begin failures++; $display("FAIL fast_ready_full: fast_ready=%b required 0", fast_ready); end
      end
    end
    checks++;
    if (fast_drop_cnt !== 8'd2) begin failures++; $display("FAIL fast_drop_two: cnt=%0d required 2", fast_drop_cnt); end
    for (int p = 0; p < 253; p++) begin fast_valid = 1; fast_data = 12'($urandom); step(); end
    checks++;
    if (fast_drop_cnt !== 8'd255) begin failures++; $display("FAIL fast_drop_255: cnt=%0d required 255", fast_drop_cnt); end
    fast_valid = 1; step();
    checks++;
    if (fast_drop_cnt !== 8'd255) begin failures++; $display("FAIL fast_drop_saturate: cnt=%0d required 255", fast_drop_cnt); end
    fifo_afull = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (write_enable_rx !== 1'b1 || data_to_fifo_rx !== kept[k] || tag_to_fifo_rx !== 2'b00) begin
        failures++; $display("FAIL drop_drain%0d: we=%b data=%h tag=%b required 1/%h/00", k, write_enable_rx, data_to_fifo_rx, tag_to_fifo_rx, kept[k]);
      end
    end
    step();
  endtask

  task automatic test_reset_in_slow_lo();
    slow_valid = 1; slow_id = 8'h77; slow_data = 16'h9ABC;
    step();
    step();
    #1 reset_rx = 1;
    #1;
    checks++;
    if (write_enable_rx !== 1'b0 || fast_drop_cnt !== 8'd0 || slow_drop_cnt !== 8'd0) begin
      failures++; $display("FAIL reset_async: we=%b fcnt=%0d scnt=%0d required 0/0/0", write_enable_rx, fast_drop_cnt, slow_drop_cnt);
    end
    model_reset();
    #1 reset_rx = 0;
    #1;
    checks++;
    if (fast_ready !== 1'b1 || slow_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: frdy=%b srdy=%b required 1/1", fast_ready, slow_ready);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (write_enable_rx !== 1'b0) begin failures++; $display("FAIL reset_no_stale cyc%0d: we=%b required 0", c, write_enable_rx); end
    end
  endtask

  task automatic test_random_traffic();
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      fast_valid = ($urandom_range(0, 99) < 45);
      fast_data  = 12'($urandom);
      slow_valid = ($urandom_range(0, 99) < 20);
      slow_id    = 8'($urandom);
      slow_data  = 16'($urandom);
      fifo_afull = ($urandom_range(0, 99) < 25);
      arb_enable = ($urandom_range(0, 99) < 85);
      step();
      checks++;
      if (write_enable_rx !== exp_we || data_to_fifo_rx !== exp_data || tag_to_fifo_rx !== exp_tag ||
          fast_ready !== (fq.size() < FD) || slow_ready !== (sq.size() < SD) ||
          fast_drop_cnt !== exp_fcnt || slow_drop_cnt !== exp_scnt) begin
        failures++;
        if (bad < 10)
          $display("FAIL random cyc%0d: we=%b data=%h tag=%b frdy=%b srdy=%b fcnt=%0d scnt=%0d required %b/%h/%b/%b/%b/%0d/%0d",
                   c, write_enable_rx, data_to_fifo_rx, tag_to_fifo_rx, fast_ready, slow_ready, fast_drop_cnt, slow_drop_cnt,
                   exp_we, exp_data, exp_tag, fq.size() < FD, sq.size() < SD, exp_fcnt, exp_scnt);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fast_words();
    test_slow_pair();
    test_round_robin();
    test_afull_hold();
    test_drop_saturation();
    test_reset_in_slow_lo();
    test_random_traffic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
